// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Brief   : Shared ALU types and widths (multiplier FSM states, datapath width)
// Rev     : 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_seq_adder2.sv
`default_nettype none
// ============================================================================
// Module : Adder2
// Brief  : n-bit carry-lookahead adder, 4-bit lookahead groups chained by carry
// Rev    : 1.0
// ============================================================================
module Adder2 #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    localparam int c_grp = 4;

    logic [n-1:0] p_w;
    logic [n-1:0] g_w;

    assign p_w = a ^ b;
    assign g_w = a & b;

    // Every carry inside a group is a flat sum-of-products of the group carry-in.
    always_comb begin
        logic c_in_grp;
        logic c_out_grp;
        logic c_bit;
        logic p_run;
        sum       = '0;
        cout      = 1'b0;
        c_in_grp  = cin;
        c_out_grp = 1'b0;
        c_bit     = 1'b0;
        p_run     = 1'b1;
        for (int base = 0; base < n; base += c_grp) begin
            for (int i = base; (i <= base + c_grp) && (i <= n); i++) begin
                c_bit = 1'b0;
                p_run = 1'b1;
                for (int k = i - 1; k >= base; k--) begin
                    c_bit = c_bit | (g_w[k] & p_run);
                    p_run = p_run & p_w[k];
                end
                c_bit = c_bit | (p_run & c_in_grp);
                if ((i < base + c_grp) && (i < n)) begin
                    sum[i] = p_w[i] ^ c_bit;
                end else begin
                    c_out_grp = c_bit;
                end
            end
            c_in_grp = c_out_grp;
        end
        cout = c_in_grp;
    end

endmodule
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module : mult_seq
// Brief  : N x N -> 2N unsigned shift-add multiplier, one adder pass per cycle
// Rev    : 1.0
// ============================================================================
module mult_seq
    import alu_pkg::*;
#(
    parameter int N = ALU_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int                 c_cnt_w    = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    mult_state_t          state_q,   state_d;
    logic [N-1:0]         m_q,       m_d;
    logic [N:0]           acc_q,     acc_d;
    logic [N-1:0]         q_q,       q_d;
    logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
    logic [2*N-1:0]       product_q, product_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic [N-1:0]         add_b;
    logic [N-1:0]         add_sum;
    logic                 add_cout;
    logic                 unused_acc_msb;

    assign add_b = q_q[0] ? m_q : '0;

    Adder2 #(
        .n (N)
    ) u_add (
        .a    (acc_q[N-1:0]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The top accumulator bit is always zero after the shift; it only exists to hold the carry.
    assign unused_acc_msb = acc_q[N];

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            RUN: begin
                acc_d = {1'b0, add_cout, add_sum[N-1:1]};
                q_d   = {add_sum[0], q_q[N-1:1]};
                cnt_d = cnt_q + c_cnt_one;
                if (cnt_q == c_cnt_last) begin
                    product_d = {add_cout, add_sum, q_q[N-1:1]};
                    state_d   = DONE;
                end
            end
            default: begin
                if (start) begin
                    m_d     = a;
                    acc_d   = '0;
                    q_d     = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_mult_seq
// Brief  : Directed self-checking bench for mult_seq with a cycle-level model
// Rev    : 1.0
// ============================================================================
module tb_mult_seq;

    localparam int N  = 16;
    localparam int PW = 2 * N;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  a     = '0;
    logic [N-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mult_seq #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a request runs for N cycles, then the exact product appears with a one-cycle done.
    int            m_rem  = 0;
    logic          m_done = 1'b0;
    logic [PW-1:0] m_prod = '0;
    logic [PW-1:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_rem  <= N;
                m_pend <= PW'(a) * PW'(b);
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if (busy !== (m_rem > 0) || done !== m_done || product !== m_prod) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t: busy=%b done=%b product=%h, required busy=%b done=%b product=%h",
                     $time, busy, done, product, (m_rem > 0), m_done, m_prod);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Samples 1 time unit after each edge until done is seen or the budget runs out.
    task automatic wait_done(input int poke, output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            busy_cyc += int'(busy);
            if (edges == poke) begin
                #1;
                start = 1'b1;
                a     = 16'd7;
                b     = 16'd7;
            end else if (edges == poke + 1) begin
                #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [PW-1:0] exp, input int poke);
        int edges;
        int bc;
        int busy0;
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        busy0 = int'(busy);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        wait_done(poke, edges, bc);
        check({tag, "_done"},    64'(done),       64'd1);
        check({tag, "_latency"}, 64'(edges + 1),  64'(N + 1));
        check({tag, "_busy"},    64'(busy0 + bc), 64'(N));
        check({tag, "_product"}, 64'(product),    64'(exp));
    endtask

    initial begin
        int edges;
        int bc;
        int t1;
        int t2;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",    64'(busy),    64'd0);
        check("reset_done",    64'(done),    64'd0);
        check("reset_product", 64'(product), 64'd0);
        #1;
        rst_n = 1'b1;

        run_op("one_x_200", 16'd1,      16'd200,    32'd200,        -1);
        run_op("max_x_max", 16'hFFFF,   16'hFFFF,   32'hFFFE0001,   -1);
        run_op("b_zero",    16'h1234,   16'h0000,   32'd0,          -1);
        run_op("a_zero",    16'h0000,   16'hFFFF,   32'd0,          -1);
        run_op("ignored",   16'd3,      16'd5,      32'd15,          4);

        // Reset in the middle of a run
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = 16'd100;
        b     = 16'd100;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_product", 64'(product), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        run_op("after_rst", 16'd2, 16'd3, 32'd6, -1);

        // start held high: second operation launches on the DONE edge
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = 16'h8000;
        b     = 16'd2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        a = 16'd5;
        b = 16'd5;
        wait_done(-1, edges, bc);
        t1 = cyc;
        check("hold_first_done",    64'(done),    64'd1);
        check("hold_first_product", 64'(product), 64'h0001_0000);
        wait_done(-1, edges, bc);
        t2 = cyc;
        #1;
        start = 1'b0;
        check("hold_second_done",    64'(done),    64'd1);
        check("hold_second_product", 64'(product), 64'd25);
        check("hold_done_spacing",   64'(t2 - t1), 64'(N + 1));

        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
